rca_pipe_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 8-bit RCA.

---
 rtl/rca_pipe_adder_if.sv | 26 ++
 rtl/rca_pipe_adder.sv | 95 +++++++++
 tb/tb_rca_pipe_adder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rca_pipe_adder_if.sv
// Operand/result handshake bundle for rca_pipe_adder; slave side is the adder.
interface rca_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry add/sub: one CW-bit chunk per stage, STAGES-cycle latency, 1 op/cycle.
// Global stall: every stage holds while out_valid && !out_ready; in_ready mirrors the advance.
module rca_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  rca_pipe_adder_if.slave io
);
  localparam int CW = WIDTH / STAGES;

  // Stage k register holds the state after chunk k has been added.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic             ovf_q;

  logic             src_vld [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_cy  [STAGES];

  logic [CW-1:0]    ach     [STAGES];
  logic [CW-1:0]    bch     [STAGES];
  logic [CW:0]      tot     [STAGES];
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic             nxt_ovf;
  logic             adv;

  assign adv = !vld_q[STAGES-1] || io.out_ready;

  // Stage 0 feeds from the port; subtraction is folded in as A + ~B + 1.
  always_comb begin
    src_vld[0] = io.in_valid;
    src_a[0]   = io.a;
    src_b[0]   = io.sub ? ~io.b : io.b;
    src_sum[0] = '0;
    src_cy[0]  = io.sub ? 1'b1 : io.cin;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_cy[k]  = cy_q[k-1];
    end
  end

  always_comb begin
    nxt_ovf = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      ach[k]     = src_a[k][k*CW +: CW];
      bch[k]     = src_b[k][k*CW +: CW];
      tot[k]     = {1'b0, ach[k]} + {1'b0, bch[k]} + {{CW{1'b0}}, src_cy[k]};
      nxt_sum[k] = src_sum[k];
      nxt_sum[k][k*CW +: CW] = tot[k][CW-1:0];
    end
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    nxt_ovf = ach[STAGES-1][CW-1] ^ bch[STAGES-1][CW-1]
            ^ tot[STAGES-1][CW-1] ^ tot[STAGES-1][CW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
      end
      sum_q[STAGES-1] <= '0;
      cy_q[STAGES-1]  <= 1'b0;
      ovf_q           <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= src_vld[k];
        if (src_vld[k]) begin
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          sum_q[k] <= nxt_sum[k];
          cy_q[k]  <= tot[k][CW];
        end
      end
      if (src_vld[STAGES-1]) begin
        ovf_q <= nxt_ovf;
      end
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = vld_q[STAGES-1];
  assign io.sum       = sum_q[STAGES-1];
  assign io.cout      = cy_q[STAGES-1];
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_rca_pipe_adder.sv
// Directed bench for rca_pipe_adder in three shapes: 32/4, 32/1 and 8/8.
module tb_rca_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          sel;
  int          lat;
  logic        in_valid_d, cin_d, sub_d, out_ready_d;
  logic [31:0] a_d, b_d;

  rca_pipe_adder_if #(.WIDTH(32)) if_w32s4 ();
  rca_pipe_adder_if #(.WIDTH(32)) if_w32s1 ();
  rca_pipe_adder_if #(.WIDTH(8))  if_w8s8 ();

  assign if_w32s4.in_valid  = in_valid_d && (sel == 0);
  assign if_w32s4.a         = a_d;
  assign if_w32s4.b         = b_d;
  assign if_w32s4.cin       = cin_d;
  assign if_w32s4.sub       = sub_d;
  assign if_w32s4.out_ready = out_ready_d;

  assign if_w32s1.in_valid  = in_valid_d && (sel == 1);
  assign if_w32s1.a         = a_d;
  assign if_w32s1.b         = b_d;
  assign if_w32s1.cin       = cin_d;
  assign if_w32s1.sub       = sub_d;
  assign if_w32s1.out_ready = out_ready_d;

  assign if_w8s8.in_valid   = in_valid_d && (sel == 2);
  assign if_w8s8.a          = a_d[7:0];
  assign if_w8s8.b          = b_d[7:0];
  assign if_w8s8.cin        = cin_d;
  assign if_w8s8.sub        = sub_d;
  assign if_w8s8.out_ready  = out_ready_d;

  rca_pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut_w32s4 (.clk(clk), .rst(rst), .io(if_w32s4.slave));
  rca_pipe_adder #(.WIDTH(32), .STAGES(1)) u_dut_w32s1 (.clk(clk), .rst(rst), .io(if_w32s1.slave));
  rca_pipe_adder #(.WIDTH(8),  .STAGES(8)) u_dut_w8s8  (.clk(clk), .rst(rst), .io(if_w8s8.slave));

  logic        obs_vld, obs_rdy, obs_cout, obs_ovf;
  logic [31:0] obs_sum;

  always_comb begin
    obs_vld  = if_w32s4.out_valid;
    obs_rdy  = if_w32s4.in_ready;
    obs_sum  = if_w32s4.sum;
    obs_cout = if_w32s4.cout;
    obs_ovf  = if_w32s4.ovf;
    case (sel)
      1: begin
        obs_vld  = if_w32s1.out_valid;
        obs_rdy  = if_w32s1.in_ready;
        obs_sum  = if_w32s1.sum;
        obs_cout = if_w32s1.cout;
        obs_ovf  = if_w32s1.ovf;
      end
      2: begin
        obs_vld  = if_w8s8.out_valid;
        obs_rdy  = if_w8s8.in_ready;
        obs_sum  = {24'h0, if_w8s8.sum};
        obs_cout = if_w8s8.cout;
        obs_ovf  = if_w8s8.ovf;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cfg %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int n;
    out_ready_d = 1'b1;
    a_d = a; b_d = b; cin_d = c; sub_d = s;
    in_valid_d = 1'b1;
    #1;
    check({tag, " in_ready"}, obs_rdy, 1);
    step();
    in_valid_d = 1'b0;
    n = 1;
    while (!obs_vld && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " sum"}, obs_sum, e_sum);
    check({tag, " cout"}, obs_cout, e_cout);
    check({tag, " ovf"}, obs_ovf, e_ovf);
    step();
  endtask

  // Six ops whose sums are 1..6, each carrying across every chunk; out_ready low in cycles 5-7.
  task automatic run_bp(input int exp_stalls);
    int sent = 0;
    int recv = 0;
    int cyc = 1;
    int stalls = 0;
    int extra = 0;
    cin_d = 1'b0; sub_d = 1'b0;
    b_d = 32'hFFFF_FFF0;
    while (recv < 6 && cyc < 60) begin
      out_ready_d = !(cyc >= 5 && cyc <= 7);
      in_valid_d  = (sent < 6);
      a_d = 32'(sent + 17);
      #1;
      if (obs_vld && !out_ready_d) begin
        stalls++;
        check("bp stall in_ready", obs_rdy, 0);
        check("bp held sum", obs_sum, 32'(recv + 1));
      end
      if (obs_vld && out_ready_d) begin
        check("bp order sum", obs_sum, 32'(recv + 1));
        check("bp cout", obs_cout, 1);
        recv++;
      end
      if (in_valid_d && obs_rdy) sent++;
      step();
      cyc++;
    end
    in_valid_d  = 1'b0;
    out_ready_d = 1'b1;
    check("bp delivered", recv, 6);
    check("bp stall cycles", stalls, exp_stalls);
    repeat (10) begin
      if (obs_vld) extra++;
      step();
    end
    check("bp no duplicate", extra, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stale;
    sel = 0; lat = 4;
    rst = 1'b1;
    in_valid_d = 1'b1; out_ready_d = 1'b1;
    a_d = 32'h1234; b_d = 32'h1; cin_d = 1'b0; sub_d = 1'b0;
    repeat (2) step();
    check("reset out_valid", obs_vld, 0);
    check("reset sum", obs_sum, 0);
    check("reset cout", obs_cout, 0);
    check("reset ovf", obs_ovf, 0);
    rst = 1'b0;
    in_valid_d = 1'b0;
    #1;
    check("reset in_ready", obs_rdy, 1);
    stale = 0;
    repeat (lat + 2) begin
      if (obs_vld) stale++;
      step();
    end
    check("reset in_valid ignored", stale, 0);

    run_op("carry chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("ovf pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("ovf neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run_op("sub 7-5", 32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
    run_op("sub 5-7", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("add cin", 32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0);
    run_bp(3);

    out_ready_d = 1'b1;
    b_d = 32'd100;
    for (int i = 0; i < 3; i++) begin
      a_d = 32'(i + 1);
      in_valid_d = 1'b1;
      step();
    end
    in_valid_d = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      if (obs_vld) stale++;
      step();
    end
    check("midflight stale", stale, 0);
    run_op("post reset", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0);

    sel = 1; lat = 1;
    run_op("s1 carry chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_bp(3);

    sel = 2; lat = 8;
    run_op("w8 carry chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("w8 sub 5-7", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0);
    run_op("w8 ovf pos", 32'h7F, 32'h1, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
    run_bp(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
